// File: rtl/spi_pv_sampler.sv
// Periodic SPI sampler: a tick counter launches one mode-0 read frame per tick,
// round-robin over CHANNELS slaves, and reports each sample with a valid pulse.
module spi_pv_sampler #(
  parameter int WIDTH       = 4,
  parameter int CHANNELS    = 2,
  parameter int CH_BITS     = 1,
  parameter int PERIOD_BITS = 12,
  parameter int DIV_BITS    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic [DIV_BITS-1:0]    div,
  input  logic                   clr_overrun,
  input  logic                   miso,
  output logic                   sck,
  output logic [CHANNELS-1:0]    cs_n,
  output logic [WIDTH-1:0]       data,
  output logic [CH_BITS-1:0]     ch,
  output logic                   valid,
  output logic                   overrun
);

  localparam int HB = $clog2(2 * WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state_q;
  logic [PERIOD_BITS-1:0] tcnt_q;
  logic [PERIOD_BITS-1:0] tcnt_d;
  logic                   tick_s;
  logic                   half_end_s;
  logic [DIV_BITS-1:0]    div_q;
  logic [DIV_BITS-1:0]    hcnt_q;
  logic [HB-1:0]          half_q;
  logic [CH_BITS-1:0]     cur_ch_q;
  logic [CH_BITS-1:0]     sel_ch_q;
  logic [WIDTH-1:0]       shreg_q;
  logic                   sck_q;
  logic [CHANNELS-1:0]    cs_n_q;
  logic [WIDTH-1:0]       data_q;
  logic [CH_BITS-1:0]     ch_q;
  logic                   valid_q;
  logic                   ovr_q;

  function automatic logic [CHANNELS-1:0] cs_decode(input logic [CH_BITS-1:0] idx);
    cs_decode = '1;
    for (int i = 0; i < CHANNELS; i++) begin
      cs_decode[i] = (idx != CH_BITS'(i));
    end
  endfunction

  // Tick counter next state: reload from the live period on the tick cycle
  always_comb begin
    tick_s = (tcnt_q == '0);
    if (tick_s) begin
      tcnt_d = period;
    end else begin
      tcnt_d = tcnt_q - PERIOD_BITS'(1);
    end
  end

  assign half_end_s = (hcnt_q == div_q);

  // Tick counter register; zero after reset so the first tick is immediate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  // Frame sequencer with registered SPI pins and result outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      hcnt_q   <= '0;
      half_q   <= '0;
      cur_ch_q <= '0;
      sel_ch_q <= '0;
      shreg_q  <= '0;
      sck_q    <= 1'b0;
      cs_n_q   <= '1;
      data_q   <= '0;
      ch_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick_s && enable) begin
            state_q  <= SETUP;
            div_q    <= div;
            sel_ch_q <= cur_ch_q;
            cs_n_q   <= cs_decode(cur_ch_q);
            hcnt_q   <= '0;
          end
        end
        SETUP: begin
          if (half_end_s) begin
            // First rising SCK edge: capture the MSB on this same clk edge
            state_q <= SHIFT;
            hcnt_q  <= '0;
            half_q  <= '0;
            sck_q   <= 1'b1;
            shreg_q <= {shreg_q[WIDTH-2:0], miso};
          end else begin
            hcnt_q <= hcnt_q + DIV_BITS'(1);
          end
        end
        SHIFT: begin
          if (half_end_s) begin
            hcnt_q <= '0;
            if (half_q == HB'(2 * WIDTH - 1)) begin
              state_q <= HOLD;
              sck_q   <= 1'b0;
            end else begin
              half_q <= half_q + HB'(1);
              sck_q  <= ~sck_q;
              if (!sck_q) begin
                shreg_q <= {shreg_q[WIDTH-2:0], miso};
              end
            end
          end else begin
            hcnt_q <= hcnt_q + DIV_BITS'(1);
          end
        end
        HOLD: begin
          if (half_end_s) begin
            state_q <= DONE;
            cs_n_q  <= '1;
            data_q  <= shreg_q;
            ch_q    <= sel_ch_q;
            valid_q <= 1'b1;
          end else begin
            hcnt_q <= hcnt_q + DIV_BITS'(1);
          end
        end
        DONE: begin
          state_q  <= IDLE;
          cur_ch_q <= (cur_ch_q == CH_BITS'(CHANNELS - 1)) ? '0 : cur_ch_q + CH_BITS'(1);
        end
        default: begin
          state_q <= IDLE;
          sck_q   <= 1'b0;
          cs_n_q  <= '1;
        end
      endcase
    end
  end

  // Sticky overrun: a dropped tick takes priority over a clear request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovr_q <= 1'b0;
    end else if (tick_s && (state_q != IDLE)) begin
      ovr_q <= 1'b1;
    end else if (clr_overrun) begin
      ovr_q <= 1'b0;
    end
  end

  assign sck     = sck_q;
  assign cs_n    = cs_n_q;
  assign data    = data_q;
  assign ch      = ch_q;
  assign valid   = valid_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_spi_pv_sampler.sv
// Scoreboard bench for spi_pv_sampler: a tick/frame timeline model predicts each
// sample, chip-select window and overrun state; a monitor matches valid pulses.
module tb_spi_pv_sampler;
  localparam int W = 4;
  localparam int C = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [11:0]  period = 12'd20;
  logic [3:0]   div = 4'd0;
  logic         clr_overrun = 1'b0;
  logic         miso = 1'b0;
  logic         sck;
  logic [C-1:0] cs_n;
  logic [W-1:0] data;
  logic [0:0]   ch;
  logic         valid;
  logic         overrun;

  spi_pv_sampler #(.WIDTH(W), .CHANNELS(C), .CH_BITS(1), .PERIOD_BITS(12), .DIV_BITS(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period), .div(div),
    .clr_overrun(clr_overrun), .miso(miso), .sck(sck), .cs_n(cs_n), .data(data),
    .ch(ch), .valid(valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int at; int chn; logic [W-1:0] word; } exp_t;
  exp_t exq[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  int           m_cnt = 0;
  bit           m_busy = 0;
  int           m_t = 0;
  int           m_end = 0;
  int           m_fch = 0;
  int           m_ch = 0;
  bit           m_ovr = 0;
  logic [W-1:0] slave_word [C];
  logic [W-1:0] forced[$];
  logic [W-1:0] hold_data = '0;
  int           hold_ch = 0;
  int           rises = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Evaluate the tick/frame rules for the cycle now in progress
  task automatic model_eval();
    bit tk, idle, setv;
    int len;
    tk   = (m_cnt == 0);
    m_cnt = tk ? int'(period) : m_cnt - 1;
    idle = !(m_busy && cyc <= m_end);
    setv = 0;
    if (tk) begin
      if (idle && enable) begin
        len    = 1 + (2 * W + 2) * (int'(div) + 1);
        m_busy = 1;
        m_t    = cyc;
        m_end  = cyc + len;
        m_fch  = m_ch;
        if (forced.size() > 0) slave_word[m_ch] = forced.pop_front();
        else slave_word[m_ch] = W'($urandom);
        exq.push_back('{cyc + len, m_ch, slave_word[m_ch]});
        m_ch = (m_ch + 1) % C;
      end else if (!idle) begin
        setv = 1;
      end
    end
    if (setv) m_ovr = 1;
    else if (clr_overrun) m_ovr = 0;
  endtask

  task automatic check_outputs();
    logic [C-1:0] exp_cs;
    bit active;
    active = m_busy && (cyc >= m_t + 1) && (cyc <= m_end - 1);
    exp_cs = '1;
    if (active) exp_cs[m_fch] = 1'b0;
    chk("cs_n", 32'(cs_n), 32'(exp_cs));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (!active) chk("sck_idle", 32'(sck), 32'd0);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      model_eval();
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic model_reset();
    exq.delete();
    m_busy = 0; m_cnt = 0; m_ch = 0; m_ovr = 0;
    hold_data = '0; hold_ch = 0;
  endtask

  task automatic wait_start();
    int n = 0;
    step(1);
    while (!(m_busy && cyc == m_t + 1) && n < 200) begin
      step(1);
      n++;
    end
    if (!(m_busy && cyc == m_t + 1)) begin
      checks++; errors++;
      $display("FAIL frame_start: got no frame start expected one within 200 cycles");
    end
  endtask

  // Slave model: selected slave presents MSB first, next bit after each SCK rise
  initial begin
    logic [C-1:0] prev_cs;
    logic prev_sck;
    int act;
    prev_cs = '1; prev_sck = 1'b0; act = 0;
    forever begin
      @(negedge clk);
      if (cs_n != '1) begin
        if (prev_cs == '1) begin
          rises = 0;
          act = cs_n[0] ? 1 : 0;
        end else if (sck && !prev_sck) begin
          rises++;
        end
      end
      miso = (cs_n != '1 && rises < W) ? slave_word[act][W-1-rises] : 1'b0;
      prev_cs = cs_n;
      prev_sck = sck;
    end
  end

  // Monitor: pop the expected sample whenever the DUT reports one
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (exq.size() > 0 && exq[0].at < cyc) begin
        e = exq.pop_front();
        checks++; errors++;
        $display("FAIL missed_valid: got no valid expected one at cycle %0d", e.at);
      end
      if (valid) begin
        if (exq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid: got valid expected none (cycle %0d)", cyc);
        end else begin
          e = exq.pop_front();
          chk("valid_cycle", 32'(cyc), 32'(e.at));
          chk("data", 32'(data), 32'(e.word));
          chk("ch", 32'(ch), 32'(e.chn));
          chk("sck_rises", 32'(rises), 32'(W));
          hold_data = e.word;
          hold_ch = e.chn;
        end
      end else begin
        chk("data_hold", 32'(data), 32'(hold_data));
        chk("ch_hold", 32'(ch), 32'(hold_ch));
      end
    end
  end

  initial begin
    int n;
    slave_word[0] = '0; slave_word[1] = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'h3);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_ch", 32'(ch), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // Basic frames: ch0 = B, ch1 = C, ch0 = 3
    forced.push_back(4'hB); forced.push_back(4'hC); forced.push_back(4'h3);
    model_reset();
    reset = 1'b1; enable = 1'b1; period = 12'd20; div = 4'd0;
    step(70);

    // Overrun with long frames
    period = 12'd3; div = 4'd2;
    step(80);
    n = 0;
    while (m_cnt == 0 && n < 10) begin step(1); n++; end
    clr_overrun = 1'b1; step(1); clr_overrun = 1'b0;
    n = 0;
    while (!(m_cnt == 0 && m_busy && cyc <= m_end) && n < 50) begin step(1); n++; end
    clr_overrun = 1'b1; step(1); clr_overrun = 1'b0;
    step(40);

    // Randomized timing
    for (int r = 0; r < 6; r++) begin
      period = 12'($urandom_range(0, 40));
      div = 4'($urandom_range(0, 3));
      enable = ($urandom % 4) != 0;
      for (int k = 0; k < 100; k++) begin
        clr_overrun = ($urandom % 16) == 0;
        step(1);
      end
      clr_overrun = 1'b0;
    end

    // Reset in the middle of SHIFT
    enable = 1'b1; period = 12'd20; div = 4'd1;
    wait_start();
    step(3);
    reset = 1'b0;
    #1;
    chk("abort_cs_n", 32'(cs_n), 32'h3);
    chk("abort_sck", 32'(sck), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    step(60);

    // Drop enable during SETUP
    div = 4'd0;
    wait_start();
    enable = 1'b0;
    step(60);

    // div change mid-frame only affects the next frame
    enable = 1'b1; div = 4'd0;
    wait_start();
    div = 4'd3;
    step(120);

    n = 0;
    while (exq.size() > 0 && n < 200) begin step(1); n++; end
    if (exq.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending samples expected 0", exq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_pv_sampler.md
SPI_PV_SAMPLER -- requirements
Module: spi_pv_sampler

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bits per sample frame (2..16).
REQ-002 SHALL have parameter CHANNELS, default 2: number of SPI slaves, each with its own chip select (1..8).
REQ-003 SHALL have parameter CH_BITS, default 1: width of the channel index; 2^CH_BITS >= CHANNELS.
REQ-004 SHALL have parameter PERIOD_BITS, default 12: width of the sample-period counter.
REQ-005 SHALL have parameter DIV_BITS, default 4: width of the SCK divider.
REQ-006 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: reset, asynchronous and active-low (0 = in reset).
REQ-008 SHALL have port enable, input, 1: 1 allows new frames to start.
REQ-009 SHALL have port period, input, PERIOD_BITS: sample tick interval minus 1, in clk cycles.
REQ-010 SHALL have port div, input, DIV_BITS: SCK half-period minus 1, in clk cycles.
REQ-011 SHALL have port clr_overrun, input, 1: pulse that clears the overrun flag.
REQ-012 SHALL have port miso, input, 1: shared serial data from the slaves.
REQ-013 SHALL have port sck, output, 1: SPI clock, mode 0 (idles low).
REQ-014 SHALL have port cs_n, output, CHANNELS: per-channel chip select, active low.
REQ-015 SHALL have port data, output, WIDTH: last completed sample.
REQ-016 SHALL have port ch, output, CH_BITS: channel index of data.
REQ-017 SHALL have port valid, output, 1: one-cycle pulse when data and ch update.
REQ-018 SHALL have port overrun, output, 1: sticky flag; a tick was dropped.

Function
REQ-019 Tick counter SHALL load period and decrement each cycle; tick asserts for one cycle when count == 0, and the counter reloads from the live period value that cycle; period = 0 gives a tick every cycle.
REQ-020 FSM SHALL have states IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-021 IDLE -> SETUP when tick & enable; div and the current channel index SHALL be latched at this transition; changes to div mid-frame have no effect.
REQ-022 In SETUP, SHIFT and HOLD, cs_n[latched ch] SHALL be 0; all other cs_n bits SHALL be 1 at all times.
REQ-023 SETUP SHALL last div+1 cycles with sck = 0.
REQ-024 SHIFT SHALL last 2*WIDTH*(div+1) cycles: sck toggles every div+1 cycles, starting high, ending low; WIDTH rising edges in total.
REQ-025 miso SHALL be sampled into the shift register on the clk edge where sck goes 0->1, MSB first.
REQ-026 HOLD SHALL last div+1 cycles with sck = 0; the FSM then enters DONE.
REQ-027 DONE SHALL last one cycle: all cs_n = 1, data <= shift register, ch <= latched index, valid = 1, channel index advances (CHANNELS-1 wraps to 0); next state IDLE.
REQ-028 Tick-to-valid latency SHALL be 1 + (2*WIDTH+2)*(div+1) cycles (WIDTH=4, div=0: 11 cycles).
REQ-029 A tick arriving while the FSM is not IDLE SHALL be dropped and SHALL set overrun; a tick in IDLE with enable = 0 SHALL be ignored without setting overrun.
REQ-030 If clr_overrun and an overrun set occur in the same cycle, set SHALL win.
REQ-031 Deasserting enable mid-frame SHALL let the frame complete, including its valid pulse; no further frames start.
REQ-032 data and ch SHALL hold their values between valid pulses.
REQ-033 The channel index SHALL advance only in DONE, so no channel is skipped when ticks are dropped.

Reset
REQ-034 While reset = 0, asynchronously: FSM = IDLE, sck = 0, cs_n = all 1s, data = 0, ch = 0, valid = 0, overrun = 0, channel index = 0, tick counter = 0 (first tick on the first cycle after release).
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately; no valid pulse is produced for it.

Verification
REQ-036 WIDTH=4, div=0, period=20, enable=1, ch0 slave returns 1011 -> cs_n[0] low 10 cycles, 4 sck rising edges, valid 11 cycles after tick, data=4'hB, ch=0.
REQ-037 Two successive frames, CHANNELS=2, slaves return 0x3 and 0xC -> cs_n[0] then cs_n[1] asserted; outputs (ch=0, data=3) then (ch=1, data=C); third frame targets ch0.
REQ-038 period=3, div=2 (frame length 31 cycles) -> overrun=1 after first dropped tick; no channel skipped; clr_overrun pulse in a cycle with no tick clears it; clr_overrun coincident with a dropped tick leaves it 1.
REQ-039 Assert reset during SHIFT -> cs_n all 1s and sck=0 immediately, no valid; after release the next frame starts on ch0.
REQ-040 Drop enable during SETUP -> that frame completes with valid; no later cs_n activity while enable=0.
REQ-041 Change div from 0 to 3 mid-frame -> current frame keeps 1-cycle half-periods; next frame uses 4-cycle half-periods.
